// File: rtl/nmi2apb_bridge.sv
// NMI to APB4 bridge: address decode, SETUP/ACCESS sequencing, rdata mux, errors.
// Optional ACCESS-phase timeout compiled in with `define APB_TIMEOUT_EN.
module nmi2apb_bridge #(
  parameter int          NUM_SLV     = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          SLV_AW      = 12,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    nmi_valid_i,
  input  logic [31:0]             nmi_addr_i,
  input  logic [31:0]             nmi_wdata_i,
  input  logic [3:0]              nmi_wstrb_i,
  output logic [31:0]             nmi_rdata_o,
  output logic                    nmi_ready_o,
  output logic [31:0]             apb_paddr_o,
  output logic [2:0]              apb_pprot_o,
  output logic [NUM_SLV-1:0]      apb_psel_o,
  output logic                    apb_penable_o,
  output logic                    apb_pwrite_o,
  output logic [31:0]             apb_pwdata_o,
  output logic [3:0]              apb_pstrb_o,
  input  logic [NUM_SLV-1:0]      apb_pready_i,
  input  logic [NUM_SLV*32-1:0]   apb_prdata_i,
  input  logic [NUM_SLV-1:0]      apb_pslverr_i,
  output logic                    err_o
);

  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
    $error("nmi2apb_bridge: NUM_SLV out of range");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("nmi2apb_bridge: TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]        paddr_q;
  logic [31:0]        pwdata_q;
  logic [3:0]         pstrb_q;
  logic               pwrite_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic [31:0]        off;
  logic [31:0]        blk;
  logic               hit;
  logic [NUM_SLV-1:0] sel_dec;
  logic               slv_ready;
  logic               slv_err;
  logic [31:0]        slv_rdata;
  logic               timeout;

  // Window offset and slave index of the incoming request.
  always_comb begin
    off     = nmi_addr_i - BASE_ADDR;
    blk     = off >> SLV_AW;
    hit     = (nmi_addr_i >= BASE_ADDR) &&
              (blk < 32'(NUM_SLV));
    sel_dec = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      sel_dec[k] = hit && (blk == 32'(k));
    end
  end

  // Only the currently selected slave may complete or flag an error.
  always_comb begin
    slv_ready = |(apb_pready_i & psel_q);
    slv_err   = |(apb_pslverr_i & psel_q);
    slv_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (psel_q[k]) begin
        slv_rdata = slv_rdata | apb_prdata_i[32*k +: 32];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS &&
                 tmo_cnt_q != 8'hFF) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  assign timeout = (state_q == ACCESS) &&
                   (tmo_cnt_q == 8'(TIMEOUT_CYC));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (nmi_valid_i) begin
          state_d = hit ? SETUP : RESP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (slv_ready || timeout) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pready in the limit cycle takes priority over the timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (nmi_valid_i && hit) begin
            paddr_q  <= nmi_addr_i;
            pwdata_q <= nmi_wdata_i;
            pstrb_q  <= nmi_wstrb_i;
            pwrite_q <= |nmi_wstrb_i;
            psel_q   <= sel_dec;
          end else if (nmi_valid_i) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
          end
        end
        SETUP: penable_q <= 1'b1;
        ACCESS: begin
          if (slv_ready) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rdata_q   <= pwrite_q ? '0 : slv_rdata;
            err_q     <= slv_err;
          end else if (timeout) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            rdata_q   <= ERR_RDATA;
            err_q     <= 1'b1;
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

  assign nmi_ready_o   = (state_q == RESP);
  assign nmi_rdata_o   = rdata_q;
  assign err_o         = err_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pprot_o   = 3'b000;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;

endmodule
